// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with a valid/ready output stream,
// run-time seed load and all-zero lockup recovery.
// Optional: define LFSR_GEN_STEP_CNT_EN to add step_cnt_o (accepted-beat count).
module lfsr_gen #(
    parameter int unsigned WIDTH = 32,
    parameter logic [63:0] TAPS  = 64'h0000_0000_088C_8892,
    parameter logic [63:0] SEED  = 64'h0000_0000_00BD_43C4,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             seed_we_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic             rnd_valid_o,
    input  logic             rnd_ready_i,
    output logic [STEP-1:0]  rnd_o,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
`ifdef LFSR_GEN_STEP_CNT_EN
    ,
    output logic [31:0]      step_cnt_o
`endif
);

    localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    fsm_e             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] step_d;
    logic             lockup_q;
    logic             lockup_d;
    logic             valid;
    logic             accept;
    logic             zero_state;

    // A seed write hides the beat so the consumer never takes a stale word.
    assign valid      = (fsm_q == RUN) && !seed_we_i;
    assign accept     = valid && rnd_ready_i;
    assign zero_state = (state_q == '0);

    // STEP single shifts unrolled; feedback enters bit 0 each time.
    always_comb begin
        step_d = state_q;
        for (int i = 0; i < int'(STEP); i++) begin
            step_d = {step_d[WIDTH-2:0], ^(step_d & TAPS_W)};
        end
    end

    // Next state: seed load beats lockup recovery, which beats an advance.
    always_comb begin
        state_d  = state_q;
        lockup_d = 1'b0;
        if (seed_we_i) begin
            if (seed_i == '0) begin
                state_d  = SEED_W;
                lockup_d = 1'b1;
            end else begin
                state_d = seed_i;
            end
        end else if (zero_state) begin
            state_d  = SEED_W;
            lockup_d = 1'b1;
        end else if (accept) begin
            state_d = step_d;
        end
    end

    // State register and the one-cycle lockup pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= SEED_W;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end

    // Stream FSM: RUN while enabled, unaffected by seed writes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q <= IDLE;
        end else begin
            unique case (fsm_q)
                IDLE: if (en_i) fsm_q <= RUN;
                RUN:  if (!en_i) fsm_q <= IDLE;
                default: fsm_q <= IDLE;
            endcase
        end
    end

`ifdef LFSR_GEN_STEP_CNT_EN
    logic [31:0] cnt_q;

    // Accepted-beat counter, restarted by any seed write.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (seed_we_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign step_cnt_o = cnt_q;
`endif

    assign rnd_valid_o = valid;
    assign rnd_o       = state_q[STEP-1:0];
    assign state_o     = state_q;
    assign lockup_o    = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: random-stimulus bench for lfsr_gen (STEP=1 and STEP=4 copies)
// against an arithmetic reference model.
module tb_lfsr_gen;

    localparam logic [31:0] TAPS = 32'h088C_8892;
    localparam logic [31:0] SEED = 32'h00BD_43C4;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        en_i = 1'b0;
    logic        seed_we_i = 1'b0;
    logic        rnd_ready_i = 1'b0;
    logic [31:0] seed_i = '0;

    logic        va, vb, la, lb;
    logic [0:0]  ra;
    logic [3:0]  rb;
    logic [31:0] sa, sb;
`ifdef LFSR_GEN_STEP_CNT_EN
    logic [31:0] ca, cb;
`endif

    always #5 clk = ~clk;

    lfsr_gen #(
        .WIDTH(32), .TAPS(64'(TAPS)), .SEED(64'(SEED)), .STEP(1)
    ) u_a (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
        .seed_we_i(seed_we_i), .seed_i(seed_i),
        .rnd_valid_o(va), .rnd_ready_i(rnd_ready_i),
        .rnd_o(ra), .state_o(sa), .lockup_o(la)
`ifdef LFSR_GEN_STEP_CNT_EN
        , .step_cnt_o(ca)
`endif
    );

    lfsr_gen #(
        .WIDTH(32), .TAPS(64'(TAPS)), .SEED(64'(SEED)), .STEP(4)
    ) u_b (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
        .seed_we_i(seed_we_i), .seed_i(seed_i),
        .rnd_valid_o(vb), .rnd_ready_i(rnd_ready_i),
        .rnd_o(rb), .state_o(sb), .lockup_o(lb)
`ifdef LFSR_GEN_STEP_CNT_EN
        , .step_cnt_o(cb)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] ma, mb, cnt_a, cnt_b;
    logic        m_run, lk_a, lk_b;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // n single shifts: parity of tapped bits becomes the new LSB.
    function automatic logic [31:0] adv(input logic [31:0] s, input int n);
        for (int k = 0; k < n; k++) begin
            s = (s << 1) | 32'($countones(s & TAPS) % 2);
        end
        return s;
    endfunction

    task automatic model_reset();
        ma = SEED; mb = SEED; m_run = 1'b0;
        lk_a = 1'b0; lk_b = 1'b0; cnt_a = '0; cnt_b = '0;
    endtask

    task automatic check_all();
        logic ev;
        ev = m_run && !seed_we_i;
        check("valid_a", 64'(va), 64'(ev));
        check("valid_b", 64'(vb), 64'(ev));
        check("state_a", 64'(sa), 64'(ma));
        check("state_b", 64'(sb), 64'(mb));
        check("rnd_a", 64'(ra), 64'(ma % 2));
        check("rnd_b", 64'(rb), 64'(mb % 16));
        check("lock_a", 64'(la), 64'(lk_a));
        check("lock_b", 64'(lb), 64'(lk_b));
`ifdef LFSR_GEN_STEP_CNT_EN
        check("cnt_a", 64'(ca), 64'(cnt_a));
        check("cnt_b", 64'(cb), 64'(cnt_b));
`endif
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] s, input int n,
                                        input logic acc, output logic lk);
        lk = 1'b0;
        if (seed_we_i) begin
            lk = (seed_i == 0);
            return lk ? SEED : seed_i;
        end
        if (s == 0) begin
            lk = 1'b1;
            return SEED;
        end
        return acc ? adv(s, n) : s;
    endfunction

    // One clock: predict from current inputs, then compare after the edge.
    task automatic cycle();
        logic acc, nla, nlb;
        logic [31:0] na, nb;
        acc = m_run && !seed_we_i && rnd_ready_i;
        na = nxt(ma, 1, acc, nla);
        nb = nxt(mb, 4, acc, nlb);
        @(posedge clk);
        #1;
        if (seed_we_i) begin
            cnt_a = '0; cnt_b = '0;
        end else if (acc) begin
            cnt_a = cnt_a + 1; cnt_b = cnt_b + 1;
        end
        ma = na; mb = nb; lk_a = nla; lk_b = nlb; m_run = en_i;
        check_all();
    endtask

    initial begin
        logic [3:0] held;
        model_reset();
        #12;
        check("reset_state", 64'(sa), 64'h00BD_43C4);
        check_all();
        #5 reset_i = 1'b0;
        check_all();

        en_i = 1'b1; rnd_ready_i = 1'b1;
        cycle();
        cycle();
        check("first_beat", 64'(sa), 64'h017A_8788);
        repeat (1000) cycle();

        rnd_ready_i = 1'b0;
        held = rb;
        repeat (5) cycle();
        check("hold_rnd_b", 64'(rb), 64'(held));

        rnd_ready_i = 1'b1; seed_we_i = 1'b1; seed_i = 32'h1234_5678;
        #1 check("load_valid", 64'(va), 64'd0);
        cycle();
        check("load_state", 64'(sa), 64'h1234_5678);

        seed_i = '0;
        cycle();
        check("zero_lock", 64'(la), 64'd1);
        check("zero_state", 64'(sa), 64'(SEED));
        seed_we_i = 1'b0;
        cycle();
        check("zero_pulse", 64'(la), 64'd0);

        seed_we_i = 1'b1; seed_i = 32'h8000_0000;
        cycle();
        seed_we_i = 1'b0;
        repeat (4) cycle();

        for (int i = 0; i < 2000; i++) begin
            en_i        = ($urandom_range(0, 7) != 0);
            rnd_ready_i = $urandom_range(0, 1) == 1;
            seed_we_i   = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0:       seed_i = '0;
                1:       seed_i = 32'h8000_0000;
                default: seed_i = $urandom;
            endcase
            cycle();
        end

        seed_we_i = 1'b0; en_i = 1'b1; rnd_ready_i = 1'b1;
        repeat (20) cycle();
        @(posedge clk);
        #3 reset_i = 1'b1;
        #1 model_reset();
        check("async_state", 64'(sa), 64'(SEED));
        check_all();
        @(posedge clk);
        #1 check_all();
        #2 reset_i = 1'b0;
        #1 check_all();
        cycle();
        check("restart_valid", 64'(va), 64'd1);
        repeat (10) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
